// File: rtl/mem_responder.sv
// Memory-side responder for the requester's cs/read_req/write_req handshake.
// A word array with separate read and write latencies, plus a 4-phase release before the next request.
module mem_responder #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4096,
  parameter int READ_LAT  = 3,
  parameter int WRITE_LAT = 2,
  parameter logic [DATA_W-1:0] OOR_DATA = 'hDEAD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addrin,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              mem_resp,
  output logic              busy,
  output logic              err
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range;
  logic                commit;
  logic                mem_we;
  logic [DATA_W-1:0]   rdata;

  // Unsigned compare on the full address width; a zero-extended operand keeps DEPTH == 2**ADDR_W legal.
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign commit   = (state_q == S_BUSY) && (cnt_q == '0);
  assign mem_we   = commit && wr_q && in_range;
  assign rdata    = mem_q[addr_q[IDX_W-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    dout_d  = dout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (cs && (read_req ^ write_req)) begin
          addr_d  = addrin;
          wdata_d = datain;
          wr_d    = write_req;
          cnt_d   = write_req ? WR_CNT : RD_CNT;
          state_d = S_BUSY;
        end else if (cs && read_req && write_req) begin
          err_d   = 1'b1;
          state_d = S_DROP;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          err_d   = !in_range;
          if (!wr_q) dout_d = in_range ? rdata : OOR_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: state_d = S_DROP;
      S_DROP: begin
        // A request still held after completion must not be taken again.
        if (!read_req && !write_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Request latches and array contents survive reset; writes only land on the commit edge.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
    if (mem_we) mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
  end

  assign mem_resp = (state_q == S_RESP);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign dataout  = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against an array/latency reference model.
module tb_mem_responder;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 4096;
  localparam int READ_LAT  = 3;
  localparam int WRITE_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cs;
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addrin;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              mem_resp;
  logic              busy;
  logic              err;

  int ncmp  = 0;
  int nfail = 0;

  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .OOR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req),
    .write_req(write_req), .addrin(addrin), .datain(datain),
    .dataout(dataout), .mem_resp(mem_resp), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: request, bounded wait for completion, optional hold in DROP, release.
  task automatic do_op(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input int hold);
    int    n;
    bit    oor;
    bit    early_err;
    string lat_tag;
    oor     = (int'(a) >= DEPTH);
    lat_tag = wr ? "wr_latency" : "rd_latency";
    @(negedge clk);
    cs = 1'b1; read_req = !wr; write_req = wr; addrin = a; datain = d;
    @(posedge clk); #1;
    chk("accept_busy", 32'(busy), 32'd1);
    @(negedge clk);
    addrin = ADDR_W'($urandom);
    datain = DATA_W'($urandom);
    n = 0; early_err = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (mem_resp) break;
      if (err) early_err = 1'b1;
    end
    chk(lat_tag, 32'(n), 32'(wr ? WRITE_LAT : READ_LAT));
    chk("early_err", 32'(early_err), 32'd0);
    chk("resp_err", 32'(err), 32'(oor));
    if (wr) begin
      if (!oor) ref_mem[int'(a)] = d;
    end else if (oor) begin
      last_rd = 16'hDEAD;
    end else if (ref_mem.exists(int'(a))) begin
      last_rd = ref_mem[int'(a)];
    end else begin
      last_rd = 'x;
    end
    if (!$isunknown(last_rd)) chk(wr ? "dataout_kept" : "dataout_read", 32'(dataout), 32'(last_rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("drop_hold_busy", 32'(busy), 32'd1);
      chk("drop_no_resp", 32'(mem_resp), 32'd0);
    end
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0; cs = 1'($urandom_range(0, 1));
    n = 0;
    while (n < 5) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    chk("drop_release", 32'(n), (hold == 0) ? 32'd2 : 32'd1);
    chk("idle_err", 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
    addrin = '0; datain = '0; last_rd = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp", 32'(mem_resp), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Basic write then read back
    do_op(1'b1, 14'h0010, 16'h1234, 0);
    do_op(1'b0, 14'h0010, 16'h0000, 0);

    // Requests held past completion
    do_op(1'b1, 14'h0001, 16'hAAAA, 2);
    do_op(1'b1, 14'h0002, 16'h5555, 2);
    do_op(1'b0, 14'h0001, 16'h0000, 1);
    do_op(1'b0, 14'h0002, 16'h0000, 0);

    // Out-of-range read/write and aliasing
    do_op(1'b1, 14'h0000, 16'h0F0F, 0);
    do_op(1'b0, 14'h2000, 16'h0000, 0);
    do_op(1'b1, 14'h2000, 16'hBEEF, 0);
    do_op(1'b0, 14'h0000, 16'h0000, 0);

    // Both requests at once
    @(negedge clk); cs = 1'b1; read_req = 1'b1; write_req = 1'b1; addrin = 14'h0010;
    @(posedge clk); #1;
    chk("proto_err", 32'(err), 32'd1);
    chk("proto_no_resp", 32'(mem_resp), 32'd0);
    chk("proto_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("proto_err_pulse", 32'(err), 32'd0);
    chk("proto_no_resp2", 32'(mem_resp), 32'd0);
    @(negedge clk); read_req = 1'b0; write_req = 1'b0;
    n = 0;
    while (n < 5) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    chk("proto_release", 32'(n), 32'd1);
    do_op(1'b0, 14'h0010, 16'h0000, 0);

    // Chip select low
    @(negedge clk); cs = 1'b0; read_req = 1'b1; addrin = 14'h0010;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("cs0_busy", 32'(busy), 32'd0);
      chk("cs0_resp", 32'(mem_resp), 32'd0);
    end
    @(negedge clk); read_req = 1'b0;

    // Reset during the first BUSY cycle of a write
    do_op(1'b1, 14'h0005, 16'h1111, 0);
    @(negedge clk); cs = 1'b1; write_req = 1'b1; addrin = 14'h0005; datain = 16'h7777;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_resp", 32'(mem_resp), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_dataout", 32'(dataout), 32'd0);
    last_rd = '0;
    @(negedge clk); write_req = 1'b0; cs = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_resp", 32'(mem_resp), 32'd0);
    end
    do_op(1'b0, 14'h0005, 16'h0000, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int               r;
      logic [ADDR_W-1:0] a;
      r = int'($urandom_range(0, 9));
      a = (r < 8) ? ADDR_W'(r) : ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
      do_op(1'($urandom_range(0, 1)), a, DATA_W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
